// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the parametrised serial pattern detector.
// Holds the reset pattern, the length clamp and the length-to-mask helper.
package seq_det_pkg;

  localparam logic [31:0] SEQ_DEF_PATTERN = 32'h0000_0006;
  localparam int unsigned SEQ_DEF_LEN     = 3;

  // An out-of-range length is pulled into 1..max_w rather than rejected.
  function automatic int unsigned clamp_len(input int unsigned len,
                                            input int unsigned max_w);
    if (len == 0)
      return 1;
    else if (len > max_w)
      return max_w;
    else
      return len;
  endfunction

  function automatic logic [31:0] len_mask(input int unsigned len);
    logic [31:0] m;
    m = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (i < len) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/seq_detector_param_sat_counter.sv
// Saturating up-counter with a synchronous clear that takes priority over increment.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] count_o
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i)
      count_d = '0;
    else if (inc_i && (count_q != {CNT_W{1'b1}}))
      count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      count_q <= '0;
    else
      count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/seq_detector_param.sv
// Runtime-loadable serial pattern detector with overlap control and Moore match flag w.
// Optional saturating match counter enabled by SEQ_DETECTOR_PARAM_MATCH_CNT_EN.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int               MAX_W       = 8,
  parameter int               LEN_W       = $clog2(MAX_W + 1),
  parameter logic [MAX_W-1:0] DEF_PATTERN = MAX_W'(SEQ_DEF_PATTERN),
  parameter int               DEF_LEN     = SEQ_DEF_LEN,
  parameter int               CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             a,
  input  logic             a_valid,
  input  logic             pat_load,
  input  logic [MAX_W-1:0] pat_in,
  input  logic [LEN_W-1:0] pat_len,
  input  logic             overlap,
  output logic             w,
  output logic [CNT_W-1:0] match_cnt,
  input  logic             cnt_clr
);

  logic [MAX_W-1:0] hist_q, hist_d;
  logic [MAX_W-1:0] pat_q, pat_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] fill_q, fill_d;
  logic             matched_q, matched_d;

  logic [MAX_W-1:0] hist_shift;
  logic [MAX_W-1:0] mask;
  logic [LEN_W-1:0] fill_inc;
  logic             accept;
  logic             match;

  // a is a one-way qualified stream: a bit is taken on an edge with a_valid=1
  // and no pattern load; there is no back-pressure.
  assign accept     = a_valid && !pat_load;
  assign hist_shift = {hist_q[MAX_W-2:0], a};
  assign fill_inc   = (fill_q == LEN_W'(MAX_W)) ? fill_q : fill_q + 1'b1;
  assign mask       = MAX_W'(len_mask(32'(len_q)));
  assign match      = accept && (fill_inc >= len_q) &&
                      (((hist_shift ^ pat_q) & mask) == '0);

  always_comb begin
    hist_d    = hist_q;
    pat_d     = pat_q;
    len_d     = len_q;
    fill_d    = fill_q;
    matched_d = matched_q;
    if (pat_load) begin
      pat_d     = pat_in;
      len_d     = LEN_W'(clamp_len(32'(pat_len), MAX_W));
      hist_d    = '0;
      fill_d    = '0;
      matched_d = 1'b0;
    end else if (a_valid) begin
      hist_d    = hist_shift;
      // Non-overlap restarts the fill so the next match needs len fresh bits.
      fill_d    = (match && !overlap) ? '0 : fill_inc;
      matched_d = match;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hist_q    <= '0;
      pat_q     <= DEF_PATTERN;
      len_q     <= LEN_W'(DEF_LEN);
      fill_q    <= '0;
      matched_q <= 1'b0;
    end else begin
      hist_q    <= hist_d;
      pat_q     <= pat_d;
      len_q     <= len_d;
      fill_q    <= fill_d;
      matched_q <= matched_d;
    end
  end

  assign w = matched_q;

`ifdef SEQ_DETECTOR_PARAM_MATCH_CNT_EN
  sat_counter #(
    .CNT_W(CNT_W)
  ) u_sat_counter (
    .clk    (clk),
    .rst_n  (reset),
    .inc_i  (match),
    .clr_i  (cnt_clr),
    .count_o(match_cnt)
  );
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
  assign match_cnt      = '0;
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param: defaults, gating, overlap modes, load, clamp, reset.
module tb_seq_detector_param;

  localparam int MAX_W = 8;
  localparam int LEN_W = $clog2(MAX_W + 1);
  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic             a;
  logic             a_valid;
  logic             pat_load;
  logic [MAX_W-1:0] pat_in;
  logic [LEN_W-1:0] pat_len;
  logic             overlap;
  logic             w;
  logic [CNT_W-1:0] match_cnt;
  logic             cnt_clr;

  int n_checks = 0;
  int n_err    = 0;

  seq_detector_param #(
    .MAX_W(MAX_W),
    .CNT_W(CNT_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .a        (a),
    .a_valid  (a_valid),
    .pat_load (pat_load),
    .pat_in   (pat_in),
    .pat_len  (pat_len),
    .overlap  (overlap),
    .w        (w),
    .match_cnt(match_cnt),
    .cnt_clr  (cnt_clr)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected counter value depends on whether the counter is built.
  function automatic logic [31:0] exp_cnt(input int v);
`ifdef SEQ_DETECTOR_PARAM_MATCH_CNT_EN
    return 32'(v);
`else
    return 32'(0 * v);
`endif
  endfunction

  task automatic send_bit(input logic b, input logic exp_w, input string tag);
    a        = b;
    a_valid  = 1'b1;
    pat_load = 1'b0;
    @(posedge clk);
    #1;
    check(tag, 32'(w), 32'(exp_w));
  endtask

  task automatic idle(input int n, input logic exp_w, input string tag);
    a_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      a = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      check(tag, 32'(w), 32'(exp_w));
    end
  endtask

  task automatic load(input logic [MAX_W-1:0] p, input logic [LEN_W-1:0] l);
    pat_in   = p;
    pat_len  = l;
    pat_load = 1'b1;
    a_valid  = 1'b0;
    @(posedge clk);
    #1;
    pat_load = 1'b0;
    check("load_w", 32'(w), 32'h0);
  endtask

  initial begin
    reset    = 1'b0;
    a        = 1'b0;
    a_valid  = 1'b0;
    pat_load = 1'b0;
    pat_in   = '0;
    pat_len  = '0;
    overlap  = 1'b1;
    cnt_clr  = 1'b0;

    // reset defaults
    repeat (2) @(posedge clk);
    #1;
    check("rst_w", 32'(w), 32'h0);
    check("rst_cnt", 32'(match_cnt), 32'h0);
    reset = 1'b1;

    // default 110 pattern, stream 1,1,0,1,1,0
    send_bit(1'b1, 1'b0, "def_b1");
    send_bit(1'b1, 1'b0, "def_b2");
    send_bit(1'b0, 1'b1, "def_b3");
    send_bit(1'b1, 1'b0, "def_b4");
    send_bit(1'b1, 1'b0, "def_b5");
    send_bit(1'b0, 1'b1, "def_b6");
    check("def_cnt", 32'(match_cnt), exp_cnt(2));

    // gating: w holds through idle cycles, falls on next accepted bit
    send_bit(1'b1, 1'b0, "gate_b1");
    send_bit(1'b1, 1'b0, "gate_b2");
    send_bit(1'b0, 1'b1, "gate_b3");
    idle(4, 1'b1, "gate_hold");
    send_bit(1'b1, 1'b0, "gate_fall");
    check("gate_cnt", 32'(match_cnt), exp_cnt(3));

    // 1010 overlapping: matches after bits 4 and 6; counter saturates at 3
    overlap = 1'b1;
    load(8'h0A, 4'd4);
    send_bit(1'b1, 1'b0, "ov1_b1");
    send_bit(1'b0, 1'b0, "ov1_b2");
    send_bit(1'b1, 1'b0, "ov1_b3");
    send_bit(1'b0, 1'b1, "ov1_b4");
    send_bit(1'b1, 1'b0, "ov1_b5");
    send_bit(1'b0, 1'b1, "ov1_b6");
    check("sat_cnt", 32'(match_cnt), exp_cnt(3));

    // 1010 non-overlapping: match after bit 4 only; clear on a match edge wins
    overlap = 1'b0;
    load(8'h0A, 4'd4);
    send_bit(1'b1, 1'b0, "ov0_b1");
    send_bit(1'b0, 1'b0, "ov0_b2");
    send_bit(1'b1, 1'b0, "ov0_b3");
    send_bit(1'b0, 1'b1, "ov0_b4");
    send_bit(1'b1, 1'b0, "ov0_b5");
    send_bit(1'b0, 1'b0, "ov0_b6");
    send_bit(1'b1, 1'b0, "ov0_b7");
    check("pre_clr_cnt", 32'(match_cnt), exp_cnt(3));
    cnt_clr = 1'b1;
    send_bit(1'b0, 1'b1, "ov0_b8");
    cnt_clr = 1'b0;
    check("clr_cnt", 32'(match_cnt), exp_cnt(0));
    overlap = 1'b1;

    // load together with a valid bit: the bit is discarded
    pat_in   = 8'h06;
    pat_len  = 4'd3;
    a        = 1'b1;
    a_valid  = 1'b1;
    pat_load = 1'b1;
    @(posedge clk);
    #1;
    pat_load = 1'b0;
    check("ldv_w", 32'(w), 32'h0);
    send_bit(1'b1, 1'b0, "ldv_b1");
    send_bit(1'b0, 1'b0, "ldv_b2");
    send_bit(1'b1, 1'b0, "ldv_b3");
    send_bit(1'b1, 1'b0, "ldv_b4");
    send_bit(1'b0, 1'b1, "ldv_b5");

    // len=0 clamps to 1: every 1 matches
    load(8'h01, 4'd0);
    send_bit(1'b1, 1'b1, "len1_b1");
    send_bit(1'b0, 1'b0, "len1_b2");
    send_bit(1'b1, 1'b1, "len1_b3");

    // len=15 clamps to 8: pattern A5 needs all eight bits
    load(8'hA5, 4'd15);
    send_bit(1'b1, 1'b0, "len8_b1");
    send_bit(1'b0, 1'b0, "len8_b2");
    send_bit(1'b1, 1'b0, "len8_b3");
    send_bit(1'b0, 1'b0, "len8_b4");
    send_bit(1'b0, 1'b0, "len8_b5");
    send_bit(1'b1, 1'b0, "len8_b6");
    send_bit(1'b0, 1'b0, "len8_b7");
    send_bit(1'b1, 1'b1, "len8_b8");

    // pattern bits above len are ignored
    load(8'hF6, 4'd3);
    send_bit(1'b1, 1'b0, "hi_b1");
    send_bit(1'b1, 1'b0, "hi_b2");
    send_bit(1'b0, 1'b1, "hi_b3");

    // async reset while w=1 clears immediately and restores the default pattern
    load(8'h0A, 4'd4);
    send_bit(1'b1, 1'b0, "rs_b1");
    send_bit(1'b0, 1'b0, "rs_b2");
    send_bit(1'b1, 1'b0, "rs_b3");
    send_bit(1'b0, 1'b1, "rs_b4");
    a_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    check("rs_async_w", 32'(w), 32'h0);
    check("rs_async_cnt", 32'(match_cnt), 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    send_bit(1'b1, 1'b0, "rsd_b1");
    send_bit(1'b1, 1'b0, "rsd_b2");
    send_bit(1'b0, 1'b1, "rsd_b3");

    // reset after 1,1 starts a fresh fill
    send_bit(1'b1, 1'b0, "mid_b1");
    send_bit(1'b1, 1'b0, "mid_b2");
    a_valid = 1'b0;
    #2;
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    send_bit(1'b0, 1'b0, "mid_fresh");
    send_bit(1'b1, 1'b0, "mid_b3");
    send_bit(1'b1, 1'b0, "mid_b4");
    send_bit(1'b0, 1'b1, "mid_b5");
    check("mid_cnt", 32'(match_cnt), exp_cnt(1));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
